// File: rtl/program_loader_pkg.sv
// -----------------------------------------------------------------------------
// program_loader_pkg
// Shared definitions for the byte-stream program loader: loader FSM state
// encoding, program-memory geometry and the modulo-256 checksum helper.
// -----------------------------------------------------------------------------
package program_loader_pkg;

  localparam int PM_AW    = 5;
  localparam int PM_DW    = 16;
  localparam int PM_DEPTH = 32;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HI   = 3'd1,
    S_LO   = 3'd2,
    S_WR   = 3'd3,
    S_CHK  = 3'd4,
    S_RUN  = 3'd5,
    S_ERR  = 3'd6
  } loader_state;

  // Modulo-256 accumulation step for the stream checksum.
  function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
// Write side of the CPU's 32x16 program memory. Accepts a byte stream over a
// valid/ready handshake: one length byte L (N = L[4:0]+1 words), then N words
// sent high byte first, optionally followed by a checksum byte. Words are
// written to consecutive addresses starting at 0. The CPU is held in reset
// with its clock enable low until the load completes.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   defined   : a trailing checksum byte is required; (sum of all bytes) mod
//               256 must be 0, otherwise the loader parks in ERR.
//   undefined : no checksum byte, o_error tied low.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_ce                global clock enable (low freezes all state)
//   i_byte/i_byte_valid stream input, o_byte_ready handshake (combinational)
//   i_reload            restart a load from RUN/ERR
//   o_pm_we/addr/data   program memory write port
//   o_cpu_rst/o_cpu_ce  CPU reset and clock enable
//   o_done/o_error      load finished / checksum mismatch
// -----------------------------------------------------------------------------
module program_loader
  import program_loader_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ce,
  input  logic [7:0]       i_byte,
  input  logic             i_byte_valid,
  output logic             o_byte_ready,
  input  logic             i_reload,
  output logic             o_pm_we,
  output logic [PM_AW-1:0] o_pm_addr,
  output logic [PM_DW-1:0] o_pm_data,
  output logic             o_cpu_rst,
  output logic             o_cpu_ce,
  output logic             o_done,
  output logic             o_error
);

  loader_state      r_state;
  loader_state      w_next;
  logic [PM_AW-1:0] r_last;
  logic [PM_AW-1:0] r_cnt;
  logic [7:0]       r_hi;
  logic [PM_AW-1:0] r_pm_addr;
  logic [PM_DW-1:0] r_pm_data;
  logic             w_accept;
  logic             w_last_word;

  // Byte-consuming states; CHK is only ever entered with the checksum build.
  assign o_byte_ready = i_ce & ((r_state == S_IDLE) | (r_state == S_HI) |
                                (r_state == S_LO)   | (r_state == S_CHK));
  assign w_accept     = i_byte_valid & o_byte_ready;
  assign w_last_word  = (r_cnt == r_last);

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic       w_chk_ok;

  assign w_chk_ok = (sum8(r_sum, i_byte) == 8'h00);

  // Running modulo-256 sum of the length byte and every data byte.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sum <= 8'h00;
    end else if (i_ce && w_accept) begin
      if (r_state == S_IDLE) begin
        r_sum <= i_byte;
      end else begin
        r_sum <= sum8(r_sum, i_byte);
      end
    end
  end
`endif

  // Next-state decode; state only advances on edges with i_ce high.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_HI;
        else          w_next = S_IDLE;
      end
      S_HI: begin
        if (w_accept) w_next = S_LO;
        else          w_next = S_HI;
      end
      S_LO: begin
        if (w_accept) w_next = S_WR;
        else          w_next = S_LO;
      end
      S_WR: begin
        if (w_last_word) begin
`ifdef LOADER_CHECKSUM_EN
          w_next = S_CHK;
`else
          w_next = S_RUN;
`endif
        end else begin
          w_next = S_HI;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (w_accept) w_next = w_chk_ok ? S_RUN : S_ERR;
        else          w_next = S_CHK;
      end
      S_ERR: begin
        if (i_reload) w_next = S_IDLE;
        else          w_next = S_ERR;
      end
`endif
      S_RUN: begin
        if (i_reload) w_next = S_IDLE;
        else          w_next = S_RUN;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register plus word assembly, address counter and write-port latches.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_last    <= 5'd0;
      r_cnt     <= 5'd0;
      r_hi      <= 8'h00;
      r_pm_addr <= 5'd0;
      r_pm_data <= 16'h0000;
    end else if (i_ce) begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            // L[4:0] is already N-1, i.e. the last address to be written.
            r_last <= i_byte[4:0];
            r_cnt  <= 5'd0;
          end
        end
        S_HI: begin
          if (w_accept) r_hi <= i_byte;
        end
        S_LO: begin
          if (w_accept) begin
            r_pm_data <= {r_hi, i_byte};
            r_pm_addr <= r_cnt;
          end
        end
        S_WR: begin
          // Counter stops at the last address, so it never wraps past 31.
          if (!w_last_word) r_cnt <= r_cnt + 5'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Write strobe is a pure WR decode, suppressed while the clock enable is low.
  assign o_pm_we   = (r_state == S_WR) & i_ce;
  assign o_pm_addr = r_pm_addr;
  assign o_pm_data = r_pm_data;
  assign o_cpu_rst = (r_state != S_RUN);
  assign o_cpu_ce  = (r_state == S_RUN);
  assign o_done    = (r_state == S_RUN);
`ifdef LOADER_CHECKSUM_EN
  assign o_error   = (r_state == S_ERR);
`else
  assign o_error   = 1'b0;
`endif

endmodule
